sram_burst_controller: RTL and testbench



---
 rtl/sram_burst_controller_if.sv | 37 +++
 rtl/sram_burst_controller.sv | 160 ++++++++++++++++
 tb/tb_sram_burst_controller.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_burst_controller_if.sv
// rtl/sram_burst_controller_if.sv - cache request, write-data, read-return and SRAM bus bundle
interface sram_burst_controller_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic              req_burst;
    logic [ADDR_W-1:0] req_addr;
    logic [BE_W-1:0]   req_be;
    logic [DATA_W-1:0] wdata;
    logic              wdata_ready;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              done;
    logic              mem_ce;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_rw, req_burst, req_addr, req_be, wdata, mem_rdata,
        output req_ready, wdata_ready, rdata, rdata_valid, done,
               mem_ce, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_rw, req_burst, req_addr, req_be, wdata, mem_rdata,
        input  req_ready, wdata_ready, rdata, rdata_valid, done,
               mem_ce, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sram_burst_controller.sv
// rtl/sram_burst_controller.sv - cache-line burst controller for a synchronous byte-write SRAM
module sram_burst_controller #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4,
    parameter int RD_WAIT   = 1,
    parameter int WR_WAIT   = 1
) (
    input logic clk,
    input logic rst,
    sram_burst_controller_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int LB    = $clog2(BURST_LEN);
    localparam int CNT_W = LB + 1;
    localparam int WC_W  = (WR_WAIT > 1) ? $clog2(WR_WAIT) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RD_ISSUE = 2'd1;
    localparam logic [1:0] S_RD_DRAIN = 2'd2;
    localparam logic [1:0] S_WR       = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] base_addr;
    logic              burst_q;
    logic [CNT_W-1:0]  beat;
    logic [CNT_W-1:0]  last_beat;
    logic [WC_W-1:0]   wait_cnt;
    logic [RD_WAIT-1:0] vpipe;
    logic [RD_WAIT-1:0] lpipe;
    logic              rd_done;
    logic [DATA_W-1:0] rdata_q;
    logic              rdata_valid_q;
    logic              mem_ce_q;
    logic              mem_we_q;
    logic [BE_W-1:0]   mem_be_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              rd_issue;
    logic              wait_last;
    logic              wr_final;
    logic [CNT_W-1:0]  next_beat;
    logic [ADDR_W-1:0] next_addr;

    // Critical-word-first: only the low log2(BURST_LEN) bits advance and wrap.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                    input logic burst,
                                                    input logic [CNT_W-1:0] idx);
        logic [ADDR_W-1:0] a;
        a = base;
        if (burst)
            a[LB-1:0] = base[LB-1:0] + idx[LB-1:0];
        return a;
    endfunction

    assign rd_issue  = (state == S_RD_ISSUE);
    assign wait_last = (wait_cnt == WC_W'(WR_WAIT - 1));
    assign wr_final  = (state == S_WR) && wait_last && (beat == last_beat);
    assign next_beat = beat + CNT_W'(1);
    assign next_addr = beat_addr(base_addr, burst_q, next_beat);

    assign bus.req_ready   = (state == S_IDLE) && !rst;
    assign bus.wdata_ready = !rst && (((state == S_IDLE) && bus.req_valid && bus.req_rw) ||
                                      ((state == S_WR) && wait_last && (beat != last_beat)));
    assign bus.done        = rd_done || wr_final;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.mem_ce      = mem_ce_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_be      = mem_be_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            base_addr     <= '0;
            burst_q       <= 1'b0;
            beat          <= '0;
            last_beat     <= '0;
            wait_cnt      <= '0;
            vpipe         <= '0;
            lpipe         <= '0;
            rd_done       <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            mem_ce_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_be_q      <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            // Each issued read address travels RD_WAIT stages to meet its SRAM data.
            vpipe[0] <= rd_issue;
            lpipe[0] <= rd_issue && (beat == last_beat);
            for (int k = 1; k < RD_WAIT; k++) begin
                vpipe[k] <= vpipe[k-1];
                lpipe[k] <= lpipe[k-1];
            end
            rdata_valid_q <= vpipe[RD_WAIT-1];
            rd_done       <= lpipe[RD_WAIT-1];
            if (vpipe[RD_WAIT-1])
                rdata_q <= bus.mem_rdata;

            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        base_addr  <= bus.req_addr;
                        burst_q    <= bus.req_burst;
                        beat       <= '0;
                        wait_cnt   <= '0;
                        last_beat  <= bus.req_burst ? CNT_W'(BURST_LEN - 1) : '0;
                        mem_addr_q <= bus.req_addr;
                        mem_ce_q   <= 1'b1;
                        if (bus.req_rw) begin
                            state       <= S_WR;
                            mem_we_q    <= 1'b1;
                            mem_be_q    <= bus.req_burst ? '1 : bus.req_be;
                            mem_wdata_q <= bus.wdata;
                        end else begin
                            state    <= S_RD_ISSUE;
                            mem_we_q <= 1'b0;
                            mem_be_q <= '1;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    if (beat == last_beat) begin
                        state    <= S_RD_DRAIN;
                        mem_ce_q <= 1'b0;
                    end else begin
                        beat       <= next_beat;
                        mem_addr_q <= next_addr;
                    end
                end
                S_RD_DRAIN: begin
                    if (rd_done)
                        state <= S_IDLE;
                end
                S_WR: begin
                    if (!wait_last) begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end else if (beat == last_beat) begin
                        state    <= S_IDLE;
                        mem_ce_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        mem_be_q <= '0;
                    end else begin
                        beat        <= next_beat;
                        mem_addr_q  <= next_addr;
                        mem_wdata_q <= bus.wdata;
                        wait_cnt    <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_burst_controller.sv
// tb/tb_sram_burst_controller.sv - scoreboard bench for sram_burst_controller (RD_WAIT=2, WR_WAIT=2)
module tb_sram_burst_controller;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int RW = 2;
    localparam int WW = 2;

    typedef struct {
        int          off;
        logic        we;
        logic [3:0]  be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } bus_t;

    typedef struct {
        int          off;
        logic [DW-1:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_burst_controller_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_burst_controller #(
        .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .RD_WAIT(RW), .WR_WAIT(WW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int n_acc = 0;

    bus_t bus_q[$];
    rd_t  rd_q[$];
    int   dn_q[$];
    int   wr_q[$];
    logic [DW-1:0] wq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: RW-cycle read latency, byte-masked writes
    logic [DW-1:0] mem [0:511];
    logic [DW-1:0] rpipe [RW];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                           input logic [3:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        rpipe[0] <= (bus.mem_ce && !bus.mem_we) ? mem[bus.mem_addr[8:0]] : 32'h0;
        for (int k = 1; k < RW; k++) rpipe[k] <= rpipe[k-1];
        if (bus.mem_ce && bus.mem_we)
            mem[bus.mem_addr[8:0]] <= merge(mem[bus.mem_addr[8:0]], bus.mem_wdata, bus.mem_be);
    end
    assign bus.mem_rdata = rpipe[RW-1];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input int off);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected event at offset %0d, none expected", name, off);
    endtask

    task automatic push_bus(input int off, input logic we, input logic [3:0] be,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        bus_t e;
        e.off = off; e.we = we; e.be = be; e.addr = addr; e.wd = wd;
        bus_q.push_back(e);
    endtask

    task automatic push_rd(input int off, input logic [DW-1:0] data);
        rd_t e;
        e.off = off; e.data = data;
        rd_q.push_back(e);
    endtask

    // Monitor: pops expected responses as the DUT presents them
    initial begin
        bus_t e;
        rd_t  r;
        int   o;
        logic [DW-1:0] awd;
        forever begin
            @(negedge clk);
            if (bus.req_valid && bus.req_ready) begin
                acc_cyc = cyc;
                n_acc++;
            end
            o = cyc - acc_cyc;
            if (bus.mem_ce) begin
                if (bus_q.size() == 0) unexpected("mem_bus", o);
                else begin
                    e = bus_q.pop_front();
                    awd = bus.mem_we ? bus.mem_wdata : 32'h0;
                    chk("mem_bus{off,we,be,addr,wdata}",
                        {o, bus.mem_we, bus.mem_be, bus.mem_addr, awd},
                        {e.off, e.we, e.be, e.addr, e.wd});
                end
            end
            if (bus.rdata_valid) begin
                if (rd_q.size() == 0) unexpected("rdata_valid", o);
                else begin
                    r = rd_q.pop_front();
                    chk("rdata{off,data}", {o, bus.rdata}, {r.off, r.data});
                end
            end
            if (bus.done) begin
                if (dn_q.size() == 0) unexpected("done", o);
                else chk("done_off", o, dn_q.pop_front());
            end
            if (bus.wdata_ready) begin
                if (wr_q.size() == 0) unexpected("wdata_ready", o);
                else chk("wdata_ready_off", o, wr_q.pop_front());
            end
        end
    end

    // Write-data source: advance to the next word after each wdata_ready
    initial begin
        logic pop;
        bus.wdata = '0;
        forever begin
            @(negedge clk);
            pop = bus.wdata_ready;
            @(posedge clk);
            #2;
            if (pop && wq.size() > 0) void'(wq.pop_front());
            bus.wdata = (wq.size() > 0) ? wq[0] : 32'h0;
        end
    end

    task automatic issue(input logic rw, input logic burst, input logic [AW-1:0] addr,
                         input logic [3:0] be, input logic keep, output int a);
        @(posedge clk);
        #1;
        bus.req_rw = rw; bus.req_burst = burst; bus.req_addr = addr; bus.req_be = be;
        bus.req_valid = 1'b1;
        a = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                a = cyc;
                break;
            end
        end
        if (a < 0) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: req_ready never seen, required within 200 cycles");
        end
        @(posedge clk);
        #1;
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (bus.req_ready && bus_q.size() == 0 && rd_q.size() == 0 &&
                dn_q.size() == 0 && wr_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) begin
            vectors++; miscompares++;
            $display("FAIL idle_timeout: pending bus=%0d rd=%0d done=%0d wr=%0d, required 0",
                     bus_q.size(), rd_q.size(), dn_q.size(), wr_q.size());
        end
    endtask

    function automatic logic [127:0] outs();
        return {bus.req_ready, bus.mem_ce, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata,
                bus.rdata, bus.rdata_valid, bus.done, bus.wdata_ready};
    endfunction

    initial begin
        int a, a3, a4;
        logic [DW-1:0] w [4];
        w[0] = 32'h1111_0000; w[1] = 32'h2222_0001; w[2] = 32'h3333_0002; w[3] = 32'h4444_0003;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem[9'h010] = 32'hDEAD_BEEF;
        mem[9'h020] = 32'h1122_3344;
        for (int i = 0; i < 4; i++) mem[9'h100 + i] = 32'hA0A0_0100 + i;
        bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_burst = 1'b0;
        bus.req_addr = '0; bus.req_be = '0;

        repeat (2) @(negedge clk);
        chk("reset_outputs", outs(), 128'h0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("req_ready_after_reset", bus.req_ready, 1'b1);

        // single read
        push_bus(1, 0, 4'hF, 20'h00010, 0);
        push_rd(4, 32'hDEAD_BEEF); dn_q.push_back(4);
        issue(0, 0, 20'h00010, 4'hF, 0, a);
        wait_idle();

        // wrapped burst read from 0x102
        push_bus(1, 0, 4'hF, 20'h00102, 0); push_bus(2, 0, 4'hF, 20'h00103, 0);
        push_bus(3, 0, 4'hF, 20'h00100, 0); push_bus(4, 0, 4'hF, 20'h00101, 0);
        push_rd(4, 32'hA0A0_0102); push_rd(5, 32'hA0A0_0103);
        push_rd(6, 32'hA0A0_0100); push_rd(7, 32'hA0A0_0101); dn_q.push_back(7);
        issue(0, 1, 20'h00102, 4'hF, 0, a);
        wait_idle();

        // byte-1 write, then read back accepted in the first idle cycle
        wq.push_back(32'h0000_AB00); wr_q.push_back(0);
        push_bus(1, 1, 4'b0010, 20'h00020, 32'h0000_AB00);
        push_bus(2, 1, 4'b0010, 20'h00020, 32'h0000_AB00); dn_q.push_back(2);
        push_bus(1, 0, 4'hF, 20'h00020, 0); push_rd(4, 32'h1122_AB44); dn_q.push_back(4);
        issue(1, 0, 20'h00020, 4'b0010, 1, a3);
        issue(0, 0, 20'h00020, 4'hF, 0, a4);
        chk("back_to_back_gap", a4 - a3, 3);
        wait_idle();

        // burst write, each beat held two cycles
        for (int i = 0; i < 4; i++) begin
            wq.push_back(w[i]);
            wr_q.push_back(2 * i);
            push_bus(2 * i + 1, 1, 4'hF, 20'h00040 + i, w[i]);
            push_bus(2 * i + 2, 1, 4'hF, 20'h00040 + i, w[i]);
        end
        dn_q.push_back(8);
        issue(1, 1, 20'h00040, 4'h0, 0, a);
        wait_idle();

        // burst read of the written line starting at 0x41
        push_bus(1, 0, 4'hF, 20'h00041, 0); push_bus(2, 0, 4'hF, 20'h00042, 0);
        push_bus(3, 0, 4'hF, 20'h00043, 0); push_bus(4, 0, 4'hF, 20'h00040, 0);
        push_rd(4, w[1]); push_rd(5, w[2]); push_rd(6, w[3]); push_rd(7, w[0]); dn_q.push_back(7);
        issue(0, 1, 20'h00041, 4'hF, 0, a);
        wait_idle();

        // reset in cycle A+3 of a burst read
        push_bus(1, 0, 4'hF, 20'h00102, 0); push_bus(2, 0, 4'hF, 20'h00103, 0);
        issue(0, 1, 20'h00102, 4'hF, 0, a);
        @(posedge clk);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk("reset_midop_outputs", outs(), 128'h0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("reset_flush_pending", {bus_q.size(), rd_q.size(), dn_q.size()}, 96'h0);

        // normal burst read after reset
        push_bus(1, 0, 4'hF, 20'h00103, 0); push_bus(2, 0, 4'hF, 20'h00100, 0);
        push_bus(3, 0, 4'hF, 20'h00101, 0); push_bus(4, 0, 4'hF, 20'h00102, 0);
        push_rd(4, 32'hA0A0_0103); push_rd(5, 32'hA0A0_0100);
        push_rd(6, 32'hA0A0_0101); push_rd(7, 32'hA0A0_0102); dn_q.push_back(7);
        issue(0, 1, 20'h00103, 4'hF, 0, a);
        wait_idle();

        // zero byte-enable write keeps full timing but changes nothing
        wq.push_back(32'hFFFF_FFFF); wr_q.push_back(0);
        push_bus(1, 1, 4'h0, 20'h00010, 32'hFFFF_FFFF);
        push_bus(2, 1, 4'h0, 20'h00010, 32'hFFFF_FFFF); dn_q.push_back(2);
        issue(1, 0, 20'h00010, 4'h0, 0, a);
        wait_idle();
        push_bus(1, 0, 4'hF, 20'h00010, 0); push_rd(4, 32'hDEAD_BEEF); dn_q.push_back(4);
        issue(0, 0, 20'h00010, 4'hF, 0, a);
        wait_idle();

        repeat (4) @(negedge clk);
        chk("accept_count", n_acc, 10);
        chk("queues_empty", {bus_q.size(), rd_q.size(), dn_q.size(), wr_q.size()}, 128'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
